detagger_var: RTL and testbench



---
 rtl/detagger_var.sv | 249 ++++++++++++++++++++++++
 tb/tb_detagger_var.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/detagger_var.sv
// Variable-size tag stripper: removes a per-packet tag window at a fixed byte offset,
// compacts the remaining bytes across beats and exports the stripped tag.
module detagger_var #(
  parameter int unsigned AXIS_BUS_WIDTH    = 64,
  parameter int unsigned AXIS_ID_WIDTH     = 4,
  parameter int unsigned TAG_OFFSET        = 12,
  parameter int unsigned MIN_TAG_SIZE_BITS = 32,
  parameter int unsigned MAX_TAG_SIZE_BITS = 64,
  parameter int unsigned CNT_WIDTH         = 32,
  localparam int unsigned NUM_BUS_BYTES    = AXIS_BUS_WIDTH / 8,
  localparam int unsigned NUM_AXIS_ID      = 2 ** AXIS_ID_WIDTH,
  localparam int unsigned NUM_TAG_SIZES    = (MAX_TAG_SIZE_BITS - MIN_TAG_SIZE_BITS) / 16 + 2,
  localparam int unsigned MODE_WIDTH       = $clog2(NUM_TAG_SIZES)
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [AXIS_BUS_WIDTH-1:0]    axis_in_tdata,
  input  logic [NUM_BUS_BYTES-1:0]     axis_in_tkeep,
  input  logic                         axis_in_tlast,
  input  logic                         axis_in_tvalid,
  output logic                         axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
  output logic [NUM_BUS_BYTES-1:0]     axis_out_tkeep,
  output logic                         axis_out_tlast,
  output logic                         axis_out_tvalid,
  input  logic                         axis_out_tready,
  input  logic [NUM_AXIS_ID-1:0]       route_mask_in,
  input  logic                         cus_tag_present,
  output logic [NUM_AXIS_ID-1:0]       route_mask_out,
  input  logic [MODE_WIDTH-1:0]        tag_mode,
  output logic [MAX_TAG_SIZE_BITS-1:0] tag_out,
  output logic                         tag_out_valid,
  output logic                         tag_err,
  output logic [CNT_WIDTH-1:0]         stripped_count,
  output logic [CNT_WIDTH-1:0]         short_count
);

  localparam int NB      = int'(NUM_BUS_BYTES);
  localparam int MAX_B   = int'(MAX_TAG_SIZE_BITS / 8);
  localparam int MIN_B   = int'(MIN_TAG_SIZE_BITS / 8);
  localparam int OFF     = int'(TAG_OFFSET);
  localparam int POS_CAP = OFF + MAX_B;
  localparam int PW      = $clog2(POS_CAP + 1);
  localparam int SW      = $clog2(MAX_B + 1);
  localparam int CW      = $clog2(NB + 1);

  typedef enum logic [2:0] {StIdle, StPass, StStrip, StShift, StFlush} state_e;

  state_e                       state_q, state_d;
  logic [PW-1:0]                pos_q, pos_d;
  logic [SW-1:0]                size_q, size_d;
  logic [NUM_AXIS_ID-1:0]       route_q, route_d;
  logic [AXIS_BUS_WIDTH-1:0]    carry_q, carry_d;
  logic [CW-1:0]                carry_cnt_q, carry_cnt_d;
  logic [MAX_TAG_SIZE_BITS-1:0] tag_acc_q, tag_acc_d;
  logic [AXIS_BUS_WIDTH-1:0]    out_data_q, out_data_d;
  logic [NUM_BUS_BYTES-1:0]     out_keep_q, out_keep_d;
  logic                         out_last_q, out_last_d;
  logic                         out_valid_q, out_valid_d;
  logic [NUM_AXIS_ID-1:0]       out_mask_q, out_mask_d;
  logic [MAX_TAG_SIZE_BITS-1:0] tag_out_q, tag_out_d;
  logic                         tag_valid_q, tag_valid_d;
  logic                         tag_err_q, tag_err_d;
  logic [CNT_WIDTH-1:0]         stripped_q, stripped_d;
  logic [CNT_WIDTH-1:0]         short_q, short_d;

  logic                         first, accept, in_win, win_done, win_short;
  logic [NUM_AXIS_ID-1:0]       mask_cur;
  logic [MAX_TAG_SIZE_BITS-1:0] tag_new;
  logic [7:0]                   comb_bytes [2*NB];
  int                           size_cur, pos_cur, carry_n, win_end, nbytes, total, end_pos, abs_i;

  function automatic int tag_bytes(input logic present, input logic [MODE_WIDTH-1:0] mode);
    int m;
    m = int'(mode);
    if (!present || m == 0 || m >= int'(NUM_TAG_SIZES)) return 0;
    return MIN_B + 2 * (m - 1);
  endfunction

  function automatic state_e next_phase(input int pos, input int size);
    if (size == 0) return StShift;
    if (pos <= OFF) return StPass;
    if (pos < OFF + size) return StStrip;
    return StShift;
  endfunction

  function automatic logic [NUM_BUS_BYTES-1:0] keep_of(input int n);
    logic [NUM_BUS_BYTES-1:0] k;
    for (int i = 0; i < NB; i++) k[i] = (i < n);
    return k;
  endfunction

  assign axis_in_tready = (~out_valid_q | axis_out_tready) & (state_q != StFlush) & ~areset;
  assign accept         = axis_in_tvalid & axis_in_tready;

  // Window classification and byte compaction: carry bytes first, then kept lanes in order.
  always_comb begin
    first    = (state_q == StIdle);
    size_cur = first ? tag_bytes(cus_tag_present, tag_mode) : int'(size_q);
    mask_cur = first ? route_mask_in : route_q;
    pos_cur  = first ? 0 : int'(pos_q);
    carry_n  = int'(carry_cnt_q);
    win_end  = OFF + size_cur;
    nbytes   = 0;
    total    = carry_n;
    abs_i    = 0;
    in_win   = 1'b0;
    tag_new  = first ? '0 : tag_acc_q;
    for (int j = 0; j < 2 * NB; j++) comb_bytes[j] = '0;
    for (int j = 0; j < NB; j++) begin
      if (j < carry_n) comb_bytes[j] = carry_q[j*8 +: 8];
    end
    for (int i = 0; i < NB; i++) begin
      abs_i  = pos_cur + i;
      in_win = (abs_i >= OFF) && (abs_i < win_end);
      if (axis_in_tkeep[i]) begin
        nbytes++;
        if (in_win) begin
          for (int t = 0; t < MAX_B; t++) begin
            if (abs_i == OFF + t) tag_new[t*8 +: 8] = axis_in_tdata[i*8 +: 8];
          end
        end else begin
          for (int j = 0; j < 2 * NB; j++) begin
            if (j == total) comb_bytes[j] = axis_in_tdata[i*8 +: 8];
          end
          total++;
        end
      end
    end
    end_pos   = pos_cur + nbytes;
    win_done  = (size_cur > 0) && (pos_cur < win_end) && (end_pos >= win_end);
    win_short = (size_cur > 0) && axis_in_tlast && (end_pos > OFF) && (end_pos < win_end);
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    size_d      = size_q;
    route_d     = route_q;
    carry_d     = carry_q;
    carry_cnt_d = carry_cnt_q;
    tag_acc_d   = tag_acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q & ~axis_out_tready;
    tag_out_d   = tag_out_q;
    tag_valid_d = 1'b0;
    tag_err_d   = 1'b0;
    stripped_d  = stripped_q;
    short_d     = short_q;

    if (state_q == StFlush) begin
      if (~out_valid_q | axis_out_tready) begin
        out_valid_d = 1'b1;
        out_data_d  = carry_q;
        out_keep_d  = keep_of(carry_n);
        out_last_d  = 1'b1;
        out_mask_d  = route_q;
        carry_d     = '0;
        carry_cnt_d = '0;
        state_d     = StIdle;
      end
    end else if (accept) begin
      size_d    = SW'(size_cur);
      route_d   = mask_cur;
      pos_d     = PW'((end_pos > POS_CAP) ? POS_CAP : end_pos);
      tag_acc_d = tag_new;
      if (win_done || win_short) begin
        tag_out_d   = tag_new;
        tag_valid_d = 1'b1;
        tag_err_d   = win_short;
        if (win_short) short_d = short_q + CNT_WIDTH'(1);
        else           stripped_d = stripped_q + CNT_WIDTH'(1);
      end
      if (total >= NB || (axis_in_tlast && total > 0)) begin
        out_valid_d = 1'b1;
        out_keep_d  = keep_of(total);
        out_last_d  = axis_in_tlast && (total <= NB);
        out_mask_d  = mask_cur;
        for (int j = 0; j < NB; j++) out_data_d[j*8 +: 8] = comb_bytes[j];
      end
      carry_d     = '0;
      carry_cnt_d = '0;
      if (total > NB) begin
        for (int j = 0; j < NB; j++) carry_d[j*8 +: 8] = comb_bytes[NB + j];
        carry_cnt_d = CW'(total - NB);
      end else if (!axis_in_tlast && total < NB) begin
        for (int j = 0; j < NB; j++) carry_d[j*8 +: 8] = comb_bytes[j];
        carry_cnt_d = CW'(total);
      end
      if (axis_in_tlast) state_d = (total > NB) ? StFlush : StIdle;
      else               state_d = next_phase(end_pos, size_cur);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      pos_q       <= '0;
      size_q      <= '0;
      route_q     <= '0;
      carry_q     <= '0;
      carry_cnt_q <= '0;
      tag_acc_q   <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      tag_out_q   <= '0;
      tag_valid_q <= 1'b0;
      tag_err_q   <= 1'b0;
      stripped_q  <= '0;
      short_q     <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      size_q      <= size_d;
      route_q     <= route_d;
      carry_q     <= carry_d;
      carry_cnt_q <= carry_cnt_d;
      tag_acc_q   <= tag_acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      tag_out_q   <= tag_out_d;
      tag_valid_q <= tag_valid_d;
      tag_err_q   <= tag_err_d;
      stripped_q  <= stripped_d;
      short_q     <= short_d;
    end
  end

  assign axis_out_tdata  = out_data_q;
  assign axis_out_tkeep  = out_keep_q;
  assign axis_out_tlast  = out_last_q;
  assign axis_out_tvalid = out_valid_q;
  assign route_mask_out  = out_mask_q;
  assign tag_out         = tag_out_q;
  assign tag_out_valid   = tag_valid_q;
  assign tag_err         = tag_err_q;
  assign stripped_count  = stripped_q;
  assign short_count     = short_q;

endmodule

// File: tb/tb_detagger_var.sv
// Bench for detagger_var: directed and random packets checked against a byte-queue model.
module tb_detagger_var;
  localparam int OFF = 12;

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] axis_in_tdata;
  logic [7:0]  axis_in_tkeep;
  logic        axis_in_tlast, axis_in_tvalid, axis_in_tready;
  logic [63:0] axis_out_tdata;
  logic [7:0]  axis_out_tkeep;
  logic        axis_out_tlast, axis_out_tvalid, axis_out_tready;
  logic [15:0] route_mask_in, route_mask_out;
  logic        cus_tag_present;
  logic [1:0]  tag_mode;
  logic [63:0] tag_out;
  logic        tag_out_valid, tag_err;
  logic [31:0] stripped_count, short_count;

  detagger_var dut (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
    .axis_out_tlast(axis_out_tlast), .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tready(axis_out_tready),
    .route_mask_in(route_mask_in), .cus_tag_present(cus_tag_present),
    .route_mask_out(route_mask_out), .tag_mode(tag_mode), .tag_out(tag_out),
    .tag_out_valid(tag_out_valid), .tag_err(tag_err),
    .stripped_count(stripped_count), .short_count(short_count)
  );

  always #5 aclk = ~aclk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [15:0] mask;
    int          cy;
  } beat_t;

  int          checks = 0, errors = 0, cyc = 0;
  int          rdy_mode = 0, rdy_low = 0, stall_seen = 0, stall_bad = 0;
  int          exp_stripped = 0, exp_short = 0;
  beat_t       out_q[$];
  logic [63:0] tag_q[$];
  logic        err_q[$];
  int          acc_cyc[$];
  logic        prev_stall = 1'b0;
  logic [88:0] prev_snap = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Output monitor: records handshaken beats and tag pulses, and watches stalled beats stay put.
  always @(negedge aclk) begin
    beat_t b;
    if (axis_out_tvalid && axis_out_tready) begin
      b.data = axis_out_tdata;
      b.keep = axis_out_tkeep;
      b.last = axis_out_tlast;
      b.mask = route_mask_out;
      b.cy   = cyc;
      out_q.push_back(b);
    end
    if (tag_out_valid) begin
      tag_q.push_back(tag_out);
      err_q.push_back(tag_err);
    end
    if (!axis_in_tready) rdy_low <= rdy_low + 1;
    if (prev_stall) begin
      stall_seen <= stall_seen + 1;
      if ({axis_out_tvalid, axis_out_tdata, axis_out_tkeep, axis_out_tlast, route_mask_out}
          !== {1'b1, prev_snap}) stall_bad <= stall_bad + 1;
    end
    prev_stall <= axis_out_tvalid && !axis_out_tready;
    prev_snap  <= {axis_out_tdata, axis_out_tkeep, axis_out_tlast, route_mask_out};
  end

  initial begin
    axis_out_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       axis_out_tready = 1'b1;
        1:       axis_out_tready = ~axis_out_tready;
        default: axis_out_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [1:0] m, input logic p, input logic [15:0] rm);
    int n = 0;
    bit acc = 1'b0;
    axis_in_tdata = d; axis_in_tkeep = k; axis_in_tlast = l; axis_in_tvalid = 1'b1;
    tag_mode = m; cus_tag_present = p; route_mask_in = rm;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = axis_in_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    acc_cyc.push_back(cyc);
    check("in_accept", 64'(acc), 64'(1));
  endtask

  // Config inputs are scrambled on every non-first beat; only first-beat values may matter.
  task automatic send_pkt(input bq_t pkt, input logic [1:0] m, input logic p,
                          input logic [15:0] rm);
    int L = pkt.size();
    int nb = (L + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d = '0;
      logic [7:0]  k = '0;
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i < L) begin
          d[i*8 +: 8] = pkt[b*8 + i];
          k[i] = 1'b1;
        end
      end
      if (b == 0) drive_beat(d, k, (b == nb - 1), m, p, rm);
      else drive_beat(d, k, (b == nb - 1), 2'($urandom), 1'($urandom), 16'($urandom));
    end
    axis_in_tvalid = 1'b0; axis_in_tlast = 1'b0; axis_in_tkeep = '0;
  endtask

  task automatic run_pkt(input string nm, input bq_t pkt, input logic [1:0] m, input logic p,
                         input logic [15:0] rm, input int exp_rdylow, input bit lat_chk);
    int   sz_tab[4] = '{0, 4, 6, 8};
    int   s, L, wend, nbeats, n, r0;
    bq_t  exp;
    logic [63:0] etag = '0;
    bit   pulse = 1'b0, eerr = 1'b0;
    s = p ? sz_tab[m] : 0;
    L = pkt.size();
    wend = L;
    if (L > OFF && s > 0) begin
      pulse = 1'b1;
      eerr  = (OFF + s > L);
      wend  = (OFF + s < L) ? OFF + s : L;
      for (int t = OFF; t < wend; t++) etag[(t-OFF)*8 +: 8] = pkt[t];
    end
    for (int i = 0; i < L; i++) if (!pulse || i < OFF || i >= wend) exp.push_back(pkt[i]);
    if (pulse) begin
      if (eerr) exp_short++;
      else exp_stripped++;
    end
    out_q.delete(); tag_q.delete(); err_q.delete(); acc_cyc.delete();
    r0 = rdy_low;
    send_pkt(pkt, m, p, rm);
    nbeats = (exp.size() + 7) / 8;
    n = 0;
    while (out_q.size() < nbeats && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (6) @(posedge aclk);
    #1;
    check({nm, ".beats"}, 64'(out_q.size()), 64'(nbeats));
    for (int b = 0; b < nbeats && b < out_q.size(); b++) begin
      logic [63:0] ed = '0;
      logic [7:0]  ek = '0;
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i < exp.size()) begin
          ed[i*8 +: 8] = exp[b*8 + i];
          ek[i] = 1'b1;
        end
      end
      check($sformatf("%s.data%0d", nm, b), out_q[b].data, ed);
      check($sformatf("%s.keep%0d", nm, b), 64'(out_q[b].keep), 64'(ek));
      check($sformatf("%s.last%0d", nm, b), 64'(out_q[b].last), 64'(b == nbeats - 1));
      check($sformatf("%s.mask%0d", nm, b), 64'(out_q[b].mask), 64'(rm));
      if (lat_chk && b < acc_cyc.size())
        check($sformatf("%s.latency%0d", nm, b), 64'(out_q[b].cy), 64'(acc_cyc[b]));
    end
    check({nm, ".pulses"}, 64'(tag_q.size()), 64'(pulse));
    if (pulse && tag_q.size() > 0) begin
      check({nm, ".tag"}, tag_q[0], etag);
      check({nm, ".tag_err"}, 64'(err_q[0]), 64'(eerr));
    end
    check({nm, ".stripped"}, 64'(stripped_count), 64'(exp_stripped));
    check({nm, ".short"}, 64'(short_count), 64'(exp_short));
    if (exp_rdylow >= 0) check({nm, ".flush_cycles"}, 64'(rdy_low - r0), 64'(exp_rdylow));
  endtask

  function automatic bq_t ramp(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'(i));
    return q;
  endfunction

  task automatic check_reset_outputs(input string nm);
    check({nm, ".tvalid"}, 64'(axis_out_tvalid), 64'(0));
    check({nm, ".tlast"}, 64'(axis_out_tlast), 64'(0));
    check({nm, ".tkeep"}, 64'(axis_out_tkeep), 64'(0));
    check({nm, ".tdata"}, axis_out_tdata, 64'(0));
    check({nm, ".tag_out"}, tag_out, 64'(0));
    check({nm, ".tag_valid"}, 64'(tag_out_valid), 64'(0));
    check({nm, ".tag_err"}, 64'(tag_err), 64'(0));
    check({nm, ".stripped"}, 64'(stripped_count), 64'(0));
    check({nm, ".short"}, 64'(short_count), 64'(0));
    check({nm, ".route_mask"}, 64'(route_mask_out), 64'(0));
  endtask

  initial begin
    bq_t pkt;
    logic [63:0] d;
    areset = 1'b1; axis_in_tvalid = 1'b0; axis_in_tdata = '0; axis_in_tkeep = '0;
    axis_in_tlast = 1'b0; route_mask_in = '0; cus_tag_present = 1'b0; tag_mode = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset.in_tready", 64'(axis_in_tready), 64'(0));
    check_reset_outputs("reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    run_pkt("s0", ramp(20), 2'd2, 1'b0, 16'h1234, 0, 1'b1);
    run_pkt("m1_24", ramp(24), 2'd1, 1'b1, 16'h0005, -1, 1'b0);
    run_pkt("m1_29", ramp(29), 2'd1, 1'b1, 16'h00A0, 1, 1'b0);
    run_pkt("m3_14", ramp(14), 2'd3, 1'b1, 16'h0F00, 0, 1'b0);
    run_pkt("short12", ramp(12), 2'd3, 1'b1, 16'h0001, 0, 1'b0);
    rdy_mode = 1;
    run_pkt("m2_40", ramp(40), 2'd2, 1'b1, 16'h8001, -1, 1'b0);
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;

    // Reset lands while beat 2 of a 5-beat packet is being offered.
    d = 64'h0706050403020100;
    drive_beat(d, 8'hFF, 1'b0, 2'd1, 1'b1, 16'h00FF);
    drive_beat(d + 64'h0808080808080808, 8'hFF, 1'b0, 2'd1, 1'b1, 16'h00FF);
    axis_in_tdata = d + 64'h1010101010101010;
    areset = 1'b1;
    @(negedge aclk);
    check("midrst.in_tready", 64'(axis_in_tready), 64'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    axis_in_tvalid = 1'b0;
    @(negedge aclk);
    check_reset_outputs("midrst");
    exp_stripped = 0;
    exp_short = 0;
    @(posedge aclk);
    #1;
    run_pkt("after_rst", ramp(24), 2'd1, 1'b1, 16'h0005, -1, 1'b0);

    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      int len = $urandom_range(1, 48);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      run_pkt($sformatf("rnd%0d", k), pkt, 2'($urandom), 1'($urandom_range(0, 3) != 0),
              16'($urandom), -1, 1'b0);
    end
    rdy_mode = 0;

    check("stall_exercised", 64'(stall_seen > 0), 64'(1));
    check("stall_stable", 64'(stall_bad), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
